// File: rtl/items_sequencer.sv
// Game-flow controller between Pac-Man movement and the pellet/energizer store.
// Optional eat stall counter is built only when ITEMS_SEQ_STALL_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for the first level start
// S_RELOAD | store reload strobe high, counters cleared
// S_SETTLE | one cycle for the store counters to load
// S_PLAY   | normal play, eat detection and clear detection active
// S_CLEAR  | level cleared, eat events ignored (reported as state 0)
module items_sequencer #(
    parameter int FRIGHT_FRAMES   = 360,
    parameter int STALL_DOT       = 1,
    parameter int STALL_ENERGIZER = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_level_start,
    input  logic       i_frame_tick,
    input  logic       i_tile_valid,
    input  logic [5:0] i_tile_x,
    input  logic [5:0] i_tile_y,
    input  logic [1:0] i_tile_item,
    input  logic [7:0] i_dots_counter,
    output logic       o_items_reload,
    output logic       o_item_eaten,
    output logic [1:0] o_item_eaten_type,
    output logic [5:0] o_item_x,
    output logic [5:0] o_item_y,
    output logic       o_fright_start,
    output logic       o_fright_active,
    output logic [9:0] o_fright_frames_left,
    output logic       o_pacman_stall,
    output logic       o_level_clear,
    output logic [1:0] o_state
);

    localparam logic [1:0] ITEM_DOT       = 2'd1;
    localparam logic [1:0] ITEM_ENERGIZER = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RELOAD = 3'd1,
        S_SETTLE = 3'd2,
        S_PLAY   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       counters_clear;
    logic [9:0] fright_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Level start outranks clear detection and eats; an eat pulse in flight
    // masks both clear detection and new tile events.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_level_start) state_next = S_RELOAD;
            end
            S_RELOAD: state_next = S_SETTLE;
            S_SETTLE: state_next = S_PLAY;
            S_PLAY: begin
                if (i_level_start) begin
                    state_next = S_RELOAD;
                end else if (i_dots_counter == 8'd0 && !o_item_eaten) begin
                    state_next = S_CLEAR;
                end else begin
                    accept = i_tile_valid && !o_item_eaten &&
                             (i_tile_item == ITEM_DOT || i_tile_item == ITEM_ENERGIZER);
                end
            end
            S_CLEAR: begin
                if (i_level_start) state_next = S_RELOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Clearing on entry makes the counters read zero throughout RELOAD and CLEAR.
    assign counters_clear = (state_next == S_RELOAD) || (state_next == S_CLEAR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_item_eaten      <= 1'b0;
            o_item_eaten_type <= 2'd0;
            o_item_x          <= 6'd0;
            o_item_y          <= 6'd0;
            o_fright_start    <= 1'b0;
        end else begin
            o_item_eaten      <= accept;
            o_item_eaten_type <= accept ? i_tile_item : 2'd0;
            o_fright_start    <= accept && (i_tile_item == ITEM_ENERGIZER);
            if (accept) begin
                o_item_x <= i_tile_x;
                o_item_y <= i_tile_y;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fright_cnt <= 10'd0;
        end else if (counters_clear) begin
            fright_cnt <= 10'd0;
        end else if (accept && i_tile_item == ITEM_ENERGIZER) begin
            fright_cnt <= 10'(FRIGHT_FRAMES);
        end else if (i_frame_tick && fright_cnt != 10'd0) begin
            fright_cnt <= fright_cnt - 10'd1;
        end
    end

    assign o_fright_frames_left = fright_cnt;
    assign o_fright_active      = (fright_cnt != 10'd0);

`ifdef ITEMS_SEQ_STALL_EN
    logic [2:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= 3'd0;
        end else if (counters_clear) begin
            stall_cnt <= 3'd0;
        end else if (accept) begin
            stall_cnt <= (i_tile_item == ITEM_ENERGIZER) ? 3'(STALL_ENERGIZER) : 3'(STALL_DOT);
        end else if (i_frame_tick && stall_cnt != 3'd0) begin
            stall_cnt <= stall_cnt - 3'd1;
        end
    end

    assign o_pacman_stall = (stall_cnt != 3'd0);
`else
    assign o_pacman_stall = 1'b0;
`endif

    assign o_items_reload = (state == S_RELOAD);
    assign o_level_clear  = (state == S_CLEAR);
    assign o_state        = (state == S_CLEAR) ? 2'd0 : state[1:0];

endmodule

// File: tb/tb_items_sequencer.sv
// Directed self-checking bench for items_sequencer with FRIGHT_FRAMES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_items_sequencer;

    localparam int FF = 4;
`ifdef ITEMS_SEQ_STALL_EN
    localparam logic STALL_ON = 1'b1;
`else
    localparam logic STALL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       level_start;
    logic       frame_tick;
    logic       tile_valid;
    logic [5:0] tile_x;
    logic [5:0] tile_y;
    logic [1:0] tile_item;
    logic [7:0] dots_counter;
    logic       items_reload;
    logic       item_eaten;
    logic [1:0] item_eaten_type;
    logic [5:0] item_x;
    logic [5:0] item_y;
    logic       fright_start;
    logic       fright_active;
    logic [9:0] fright_frames_left;
    logic       pacman_stall;
    logic       level_clear;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    items_sequencer #(
        .FRIGHT_FRAMES(FF),
        .STALL_DOT(1),
        .STALL_ENERGIZER(3)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_level_start(level_start),
        .i_frame_tick(frame_tick),
        .i_tile_valid(tile_valid),
        .i_tile_x(tile_x),
        .i_tile_y(tile_y),
        .i_tile_item(tile_item),
        .i_dots_counter(dots_counter),
        .o_items_reload(items_reload),
        .o_item_eaten(item_eaten),
        .o_item_eaten_type(item_eaten_type),
        .o_item_x(item_x),
        .o_item_y(item_y),
        .o_fright_start(fright_start),
        .o_fright_active(fright_active),
        .o_fright_frames_left(fright_frames_left),
        .o_pacman_stall(pacman_stall),
        .o_level_clear(level_clear),
        .o_state(state)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame_pulse();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic eat(input logic [5:0] x, input logic [5:0] y, input logic [1:0] item);
        tile_valid = 1'b1;
        tile_x     = x;
        tile_y     = y;
        tile_item  = item;
        cyc();
        tile_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        checks++;
        if ({items_reload, item_eaten, item_eaten_type, item_x, item_y, fright_start,
             fright_active, fright_frames_left, pacman_stall, level_clear, state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d reload=%0b eaten=%0b frames=%0d",
                     state, items_reload, item_eaten, fright_frames_left);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_level_start();
        logic [1:0] exp_state [3] = '{2'd1, 2'd2, 2'd3};
        logic       exp_rel   [3] = '{1'b1, 1'b0, 1'b0};
        level_start = 1'b1;
        cyc();
        level_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== exp_state[i] || items_reload !== exp_rel[i]) begin
                errors++;
                $display("FAIL start_seq_%0d state=%0d reload=%0b expected state=%0d reload=%0b",
                         i, state, items_reload, exp_state[i], exp_rel[i]);
            end
            checks++;
            if (item_eaten !== 1'b0 || fright_active !== 1'b0 || level_clear !== 1'b0) begin
                errors++;
                $display("FAIL start_quiet_%0d eaten=%0b fright=%0b clear=%0b expected 0",
                         i, item_eaten, fright_active, level_clear);
            end
            if (i < 2) cyc();
        end
    endtask

    task automatic test_dot_eat();
        eat(6'd5, 6'd7, 2'd1);
        checks++;
        if (item_eaten !== 1'b1 || item_eaten_type !== 2'd1 || item_x !== 6'd5 || item_y !== 6'd7) begin
            errors++;
            $display("FAIL dot_eat eaten=%0b type=%0d x=%0d y=%0d expected 1 1 5 7",
                     item_eaten, item_eaten_type, item_x, item_y);
        end
        checks++;
        if (pacman_stall !== STALL_ON || fright_start !== 1'b0) begin
            errors++;
            $display("FAIL dot_side stall=%0b fstart=%0b expected %0b 0", pacman_stall, fright_start, STALL_ON);
        end
        eat(6'd6, 6'd7, 2'd1);
        checks++;
        if (item_eaten !== 1'b0 || item_eaten_type !== 2'd0 || item_x !== 6'd5) begin
            errors++;
            $display("FAIL dot_drop eaten=%0b type=%0d x=%0d expected 0 0 5", item_eaten, item_eaten_type, item_x);
        end
        eat(6'd8, 6'd9, 2'd3);
        checks++;
        if (item_eaten !== 1'b0) begin
            errors++;
            $display("FAIL reserved_item eaten=%0b expected 0", item_eaten);
        end
        eat(6'd8, 6'd9, 2'd0);
        checks++;
        if (item_eaten !== 1'b0) begin
            errors++;
            $display("FAIL none_item eaten=%0b expected 0", item_eaten);
        end
        frame_pulse();
    endtask

    task automatic test_energizer();
        eat(6'd1, 6'd3, 2'd2);
        checks++;
        if (item_eaten !== 1'b1 || item_eaten_type !== 2'd2 || fright_start !== 1'b1 ||
            fright_frames_left !== 10'(FF) || fright_active !== 1'b1) begin
            errors++;
            $display("FAIL energizer_eat eaten=%0b type=%0d fstart=%0b frames=%0d expected 1 2 1 %0d",
                     item_eaten, item_eaten_type, fright_start, fright_frames_left, FF);
        end
        cyc();
        checks++;
        if (fright_start !== 1'b0) begin
            errors++;
            $display("FAIL fstart_width fstart=%0b expected 0", fright_start);
        end
        frame_pulse();
        frame_pulse();
        checks++;
        if (fright_frames_left !== 10'd2) begin
            errors++;
            $display("FAIL fright_two_ticks frames=%0d expected 2", fright_frames_left);
        end
        eat(6'd1, 6'd26, 2'd2);
        checks++;
        if (fright_frames_left !== 10'(FF) || fright_start !== 1'b1) begin
            errors++;
            $display("FAIL fright_reload frames=%0d fstart=%0b expected %0d 1", fright_frames_left, fright_start, FF);
        end
        frame_pulse();
        frame_pulse();
        checks++;
        if (pacman_stall !== STALL_ON) begin
            errors++;
            $display("FAIL stall_two_ticks stall=%0b expected %0b", pacman_stall, STALL_ON);
        end
        frame_pulse();
        checks++;
        if (fright_active !== 1'b1 || fright_frames_left !== 10'd1 || pacman_stall !== 1'b0) begin
            errors++;
            $display("FAIL fright_three_ticks active=%0b frames=%0d stall=%0b expected 1 1 0",
                     fright_active, fright_frames_left, pacman_stall);
        end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        checks++;
        if (fright_active !== 1'b0 || fright_frames_left !== 10'd0) begin
            errors++;
            $display("FAIL fright_expire active=%0b frames=%0d expected 0 0", fright_active, fright_frames_left);
        end
        frame_pulse();
        checks++;
        if (fright_frames_left !== 10'd0) begin
            errors++;
            $display("FAIL fright_saturate frames=%0d expected 0", fright_frames_left);
        end
    endtask

    task automatic test_restart_fright();
        eat(6'd10, 6'd10, 2'd2);
        level_start = 1'b1;
        cyc();
        level_start = 1'b0;
        checks++;
        if (state !== 2'd1 || items_reload !== 1'b1 || fright_active !== 1'b0 ||
            fright_frames_left !== 10'd0 || pacman_stall !== 1'b0) begin
            errors++;
            $display("FAIL restart_fright state=%0d reload=%0b active=%0b frames=%0d stall=%0b expected 1 1 0 0 0",
                     state, items_reload, fright_active, fright_frames_left, pacman_stall);
        end
        cyc();
        cyc();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL restart_play state=%0d expected 3", state);
        end
    endtask

    task automatic test_clear();
        dots_counter = 8'd1;
        eat(6'd2, 6'd2, 2'd1);
        dots_counter = 8'd0;
        cyc();
        checks++;
        if (state !== 2'd3 || level_clear !== 1'b0) begin
            errors++;
            $display("FAIL clear_not_in_eat state=%0d clear=%0b expected 3 0", state, level_clear);
        end
        cyc();
        checks++;
        if (level_clear !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL clear_rise clear=%0b state=%0d expected 1 0", level_clear, state);
        end
        eat(6'd4, 6'd4, 2'd1);
        checks++;
        if (item_eaten !== 1'b0 || level_clear !== 1'b1) begin
            errors++;
            $display("FAIL clear_ignore eaten=%0b clear=%0b expected 0 1", item_eaten, level_clear);
        end
        level_start = 1'b1;
        dots_counter = 8'd244;
        cyc();
        level_start = 1'b0;
        checks++;
        if (state !== 2'd1 || items_reload !== 1'b1 || level_clear !== 1'b0) begin
            errors++;
            $display("FAIL clear_restart state=%0d reload=%0b clear=%0b expected 1 1 0",
                     state, items_reload, level_clear);
        end
        cyc();
        cyc();
    endtask

    initial begin
        rst_n        = 1'b0;
        level_start  = 1'b0;
        frame_tick   = 1'b0;
        tile_valid   = 1'b0;
        tile_x       = 6'd0;
        tile_y       = 6'd0;
        tile_item    = 2'd0;
        dots_counter = 8'd244;
        test_reset();
        test_level_start();
        test_dot_eat();
        test_energizer();
        test_restart_fright();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/items_sequencer.md
# items_sequencer

Game-flow controller for the pellet/energizer store. It sequences level start, pulsing the store's reload strobe and waiting for its counters to settle. It converts Pac-Man tile-entry events into single-cycle eat commands, runs the energizer fright timer and the optional eat stall, and flags level clear when the store's remaining-dot count reaches zero. It sits between the Pac-Man movement logic and the item store.

## Interface
Parameters:
- FRIGHT_FRAMES, 360: frames of fright mode per energizer; 1..1023.
- STALL_DOT, 1: frames Pac-Man is stalled after eating a dot; 0..7.
- STALL_ENERGIZER, 3: frames Pac-Man is stalled after eating an energizer; 0..7.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_level_start  in  1  single-cycle request to (re)start a level.
- i_frame_tick  in  1  single-cycle pulse, once per video frame.
- i_tile_valid  in  1  single-cycle pulse when Pac-Man enters a new tile.
- i_tile_x  in  6  row of the entered tile, 0..35.
- i_tile_y  in  6  column of the entered tile, 0..27.
- i_tile_item  in  2  store contents at (i_tile_x, i_tile_y), valid with i_tile_valid; 0 none, 1 dot, 2 energizer, 3 reserved.
- i_dots_counter  in  8  remaining-dot count from the store.
- o_items_reload  out  1  single-cycle reload strobe to the store.
- o_item_eaten  out  1  single-cycle eat command to the store.
- o_item_eaten_type  out  2  type of the eaten item; 1 or 2 while o_item_eaten is high, else 0.
- o_item_x  out  6  row of the eaten item.
- o_item_y  out  6  column of the eaten item.
- o_fright_start  out  1  single-cycle pulse that starts or restarts fright mode.
- o_fright_active  out  1  high while the fright counter is nonzero.
- o_fright_frames_left  out  10  fright counter value.
- o_pacman_stall  out  1  high while the stall counter is nonzero.
- o_level_clear  out  1  high while in S_CLEAR.
- o_state  out  2  current FSM state.

## Operation
- All outputs and counters reset to 0; reset enters S_IDLE. Reset is honoured at any point, including mid-level.
- FSM states and encodings:
  - S_IDLE (0): on i_level_start, go to S_RELOAD.
  - S_RELOAD (1): o_items_reload is high for exactly this one cycle; fright and stall counters clear; next state S_SETTLE.
  - S_SETTLE (2): one cycle for the store counters to load; next state S_PLAY.
  - S_PLAY (3): normal play. i_level_start goes to S_RELOAD and has priority over every other event. When i_dots_counter == 0 and o_item_eaten is low, go to S_CLEAR.
  - S_CLEAR (encoded 0, distinguished internally; o_state reads 0): o_level_clear is high; fright and stall counters clear; eat events are ignored; i_level_start goes to S_RELOAD.
- Eat detection applies in S_PLAY only. A tile event is accepted when i_tile_valid is high and i_tile_item is 1 or 2.
- Values 0 and 3 are ignored.
- Any i_tile_valid arriving in a cycle where o_item_eaten is high is dropped, because the store has not yet updated.
- On an accepted event, the next cycle drives:
  - o_item_eaten = 1.
  - Type and coordinates registered from the event.
- Energizer eat:
  - In the same cycle as o_item_eaten: o_fright_start = 1 and the fright counter loads FRIGHT_FRAMES.
  - A re-load during active fright restarts the counter at full value.
- The fright counter decrements on i_frame_tick while nonzero and saturates at 0. When a load and i_frame_tick coincide, the load wins.
- Level clear is evaluated from i_dots_counter, which updates one cycle after o_item_eaten. The transition is therefore never taken in the eat-pulse cycle.

## Timing
- i_level_start at cycle N:
  - N+1: o_items_reload = 1, state S_RELOAD.
  - N+2: S_SETTLE.
  - N+3: S_PLAY.
- Eat latency: i_tile_valid at cycle N gives o_item_eaten at N+1, one cycle wide.
- Fright countdown: o_fright_active falls on the clock after the FRIGHT_FRAMES-th i_frame_tick that follows the load.
- Clear detection: i_dots_counter reaching 0 at cycle M, with o_item_eaten low, gives S_CLEAR and o_level_clear at M+1.

## Configuration
- With ITEMS_SEQ_STALL_EN defined:
  - A dot eat loads the stall counter with STALL_DOT; an energizer eat loads STALL_ENERGIZER, in the o_item_eaten cycle.
  - The counter decrements on i_frame_tick; load wins over decrement.
  - o_pacman_stall = counter nonzero. A parameter value of 0 produces no stall.
- Without ITEMS_SEQ_STALL_EN: the stall counter is not built and o_pacman_stall is constant 0.

## Test plan
- Reset, then i_level_start: o_items_reload is high for 1 cycle at N+1, o_state goes 1→2→3 on N+1..N+3, all other outputs stay 0.
- In S_PLAY, tile event (5,7) with item 1: at the next cycle o_item_eaten=1, type 1, x=5, y=7; a second i_tile_valid in that pulse cycle is dropped.
- Energizer eat with FRIGHT_FRAMES=4: o_fright_start pulses once; o_fright_active drops after the 4th frame tick. A second energizer eaten after 2 ticks reloads the counter to 4.
- i_dots_counter driven 1→0 one cycle after a dot eat: o_level_clear rises the following cycle. Later tile events give no o_item_eaten; i_level_start returns to S_RELOAD.
- i_level_start during active fright in S_PLAY: counters clear in S_RELOAD, o_items_reload pulses, o_fright_active=0.
- Stall: with ITEMS_SEQ_STALL_EN and STALL_ENERGIZER=3, o_pacman_stall stays high for 3 frame ticks after an energizer eat. Without the macro it stays 0.
